// File: rtl/mult_result_buf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_result_buf_pkg                                        |
// | Purpose : Shared types, constants and helpers for the pipelined      |
// |           multiplier with result buffer.                             |
// | Contents: state_t  - top-level FSM states                            |
// |           PIPE_LAT - multiplier pipeline depth (accept -> write)     |
// |           mag()    - operand magnitude for signed/unsigned modes     |
// | Revision: 1.0 - initial parametrised release                         |
// +----------------------------------------------------------------------+
package mult_result_buf_pkg;

  typedef enum logic [1:0] {
    IDLE_WRITE = 2'd0,
    DRAIN      = 2'd1,
    FULL       = 2'd2,
    READ       = 2'd3
  } state_t;

  localparam int PIPE_LAT = 3;

  // x holds a w-bit operand zero-extended to 32 bits. The magnitude of
  // -2^(w-1) is 2^(w-1), which still fits in w unsigned bits.
  function automatic logic [31:0] mag(input logic [31:0] x, input int w,
                                      input logic is_signed);
    logic [31:0] mask;
    logic [31:0] m;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    m    = (is_signed && x[5'(w - 1)]) ? (~x + 32'd1) : x;
    return m & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mult_result_buf_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_result_buf_if                                         |
// | Purpose : Host / result-memory bus of mult_result_buf.               |
// | Ports   : slave  - DUT view (operands, block-read request and memory |
// |                    read data in; ready, memory strobes/addresses,    |
// |                    read-back data and fill level out)                |
// |           master - host/memory view, directions reversed             |
// | Revision: 1.0 - initial parametrised release                         |
// +----------------------------------------------------------------------+
interface mult_result_buf_if #(
  parameter int W     = 16,
  parameter int DEPTH = 64
);
  import mult_result_buf_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int N  = 2 * W;

  logic          EN_mult;
  logic          signed_mode;
  logic [W-1:0]  mult_input0;
  logic [W-1:0]  mult_input1;
  logic          EN_blockRead;
  logic [N-1:0]  readMem_val;
  logic          RDY_mult;
  logic          EN_writeMem;
  logic [AW-1:0] writeMem_addr;
  logic [N-1:0]  writeMem_val;
  logic          EN_readMem;
  logic [AW-1:0] readMem_addr;
  logic          VALID_memVal;
  logic [N-1:0]  memVal_data;
  logic [AW:0]   fill_count;

  modport slave (
    input  EN_mult, signed_mode, mult_input0, mult_input1, EN_blockRead,
           readMem_val,
    output RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem,
           readMem_addr, VALID_memVal, memVal_data, fill_count
  );

  modport master (
    output EN_mult, signed_mode, mult_input0, mult_input1, EN_blockRead,
           readMem_val,
    input  RDY_mult, EN_writeMem, writeMem_addr, writeMem_val, EN_readMem,
           readMem_addr, VALID_memVal, memVal_data, fill_count
  );

endinterface
`default_nettype wire

// File: rtl/mult_result_buf_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_pipe                                                  |
// | Purpose : 3-stage W x W signed/unsigned multiplier.                  |
// |           S0: 4x4 nibble partial products of operand magnitudes      |
// |           S1: row sums, S2: final sum with optional negation         |
// | Ports   : clk_i, rst_n (async, active-low)                           |
// |           valid_i/signed_i/a_i/b_i - operation in                    |
// |           valid_o/prod_o           - product out, 3 cycles later     |
// | Revision: 1.0 - initial parametrised release                         |
// +----------------------------------------------------------------------+
module mult_pipe
  import mult_result_buf_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk_i,
  input  logic           rst_n,
  input  logic           valid_i,
  input  logic           signed_i,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic           valid_o,
  output logic [2*W-1:0] prod_o
);

  localparam int N  = 2 * W;
  localparam int NB = W / 4;
  localparam int RW = W + 4;   // one nibble times a full operand

  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;
  logic          sign_d;
  logic [7:0]    pp_d  [NB*NB];
  logic [7:0]    pp_q  [NB*NB];
  logic [RW-1:0] row_d [NB];
  logic [RW-1:0] row_q [NB];
  logic [N-1:0]  sum_w;
  logic [N-1:0]  prod_d;
  logic [N-1:0]  prod_q;
  logic          v0_q, v1_q, v2_q;
  logic          s0_q, s1_q;

  assign mag_a  = W'(mag(32'(a_i), W, signed_i));
  assign mag_b  = W'(mag(32'(b_i), W, signed_i));
  assign sign_d = signed_i & (a_i[W-1] ^ b_i[W-1]);

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      for (int j = 0; j < NB; j++) begin
        pp_d[i*NB+j] = {4'b0, mag_a[4*i +: 4]} * {4'b0, mag_b[4*j +: 4]};
      end
    end
  end

  // Row i = nibble i of A times all of B.
  always_comb begin
    for (int i = 0; i < NB; i++) begin
      row_d[i] = '0;
      for (int j = 0; j < NB; j++) begin
        row_d[i] = row_d[i] + (RW'(pp_q[i*NB+j]) << (4 * j));
      end
    end
  end

  always_comb begin
    sum_w = '0;
    for (int i = 0; i < NB; i++) begin
      sum_w = sum_w + (N'(row_q[i]) << (4 * i));
    end
    prod_d = s1_q ? (~sum_w + N'(1)) : sum_w;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s0_q   <= 1'b0;
      s1_q   <= 1'b0;
      prod_q <= '0;
      for (int k = 0; k < NB*NB; k++) pp_q[k] <= '0;
      for (int k = 0; k < NB; k++) row_q[k] <= '0;
    end else begin
      v0_q   <= valid_i;
      s0_q   <= sign_d;
      v1_q   <= v0_q;
      s1_q   <= s0_q;
      v2_q   <= v1_q;
      prod_q <= prod_d;
      for (int k = 0; k < NB*NB; k++) pp_q[k] <= pp_d[k];
      for (int k = 0; k < NB; k++) row_q[k] <= row_d[k];
    end
  end

  assign valid_o = v2_q;
  assign prod_o  = prod_q;

endmodule
`default_nettype wire

// File: rtl/mult_result_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mult_result_buf                                            |
// | Purpose : Pipelined multiplier whose products are written in order   |
// |           into an external DEPTH-entry memory, then drained as one   |
// |           block read (when full, or on a host flush request).        |
// | Ports   : CLK, rst_n (async, active-low)                             |
// |           bus (slave) - operations, memory write/read strobes and    |
// |                         addresses, read-back data, fill level        |
// | Revision: 1.0 - initial parametrised release                         |
// +----------------------------------------------------------------------+
module mult_result_buf
  import mult_result_buf_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 64
) (
  input  logic CLK,
  input  logic rst_n,
  mult_result_buf_if.slave bus
);

  localparam int AW  = $clog2(DEPTH);
  localparam int N   = 2 * W;
  localparam int IFW = $clog2(PIPE_LAT + 1);

  state_t         state_q, state_d;
  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [AW:0]    fill_q, fill_d;
  logic [IFW-1:0] inflight_q, inflight_d;
  logic           vmem_q, vmem_d;

  logic [AW+1:0]  occ;
  logic           rdy;
  logic           accept;
  logic           wr_en;
  logic           last_rd;
  logic [N-1:0]   prod;

  // Reserving slots for in-flight products guarantees none is dropped.
  assign occ     = {1'b0, fill_q} + (AW+2)'(inflight_q);
  assign rdy     = (state_q == IDLE_WRITE) && (occ < (AW+2)'(DEPTH));
  assign accept  = bus.EN_mult & rdy;
  assign last_rd = (state_q == READ) && (({1'b0, rptr_q} + (AW+1)'(1)) == fill_q);

  mult_pipe #(.W(W)) u_pipe (
    .clk_i    (CLK),
    .rst_n    (rst_n),
    .valid_i  (accept),
    .signed_i (bus.signed_mode),
    .a_i      (bus.mult_input0),
    .b_i      (bus.mult_input1),
    .valid_o  (wr_en),
    .prod_o   (prod)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_WRITE: begin
        if ((fill_q == (AW+1)'(DEPTH)) && (inflight_q == '0)) begin
          state_d = FULL;
        end else if (bus.EN_blockRead && (occ != '0)) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   if (inflight_q == '0) state_d = READ;
      FULL:    if (bus.EN_blockRead) state_d = READ;
      READ:    if (last_rd) state_d = IDLE_WRITE;
      default: state_d = IDLE_WRITE;
    endcase
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fill_d     = fill_q;
    inflight_d = inflight_q + IFW'(accept) - IFW'(wr_en);
    vmem_d     = (state_q == READ);
    if (wr_en) begin
      wptr_d = wptr_q + AW'(1);
      fill_d = fill_q + (AW+1)'(1);
    end
    if (state_q == READ) begin
      rptr_d = rptr_q + AW'(1);
      if (last_rd) begin
        wptr_d = '0;
        rptr_d = '0;
        fill_d = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE_WRITE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      fill_q     <= '0;
      inflight_q <= '0;
      vmem_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      fill_q     <= fill_d;
      inflight_q <= inflight_d;
      vmem_q     <= vmem_d;
    end
  end

  assign bus.RDY_mult      = rdy;
  assign bus.EN_writeMem   = wr_en;
  assign bus.writeMem_addr = wptr_q;
  assign bus.writeMem_val  = prod;
  assign bus.EN_readMem    = (state_q == READ);
  assign bus.readMem_addr  = rptr_q;
  assign bus.VALID_memVal  = vmem_q;
  assign bus.memVal_data   = bus.readMem_val;
  assign bus.fill_count    = fill_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_result_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mult_result_buf                                         |
// | Purpose : Directed self-checking bench for mult_result_buf, with a   |
// |           W=16/DEPTH=64 instance and a W=8/DEPTH=4 instance, each    |
// |           attached to a behavioural result memory.                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_mult_result_buf;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  mult_result_buf_if #(.W(16), .DEPTH(64)) bus16 ();
  mult_result_buf_if #(.W(8),  .DEPTH(4))  bus8 ();

  mult_result_buf #(.W(16), .DEPTH(64)) u_dut16 (.CLK(CLK), .rst_n(rst_n), .bus(bus16.slave));
  mult_result_buf #(.W(8),  .DEPTH(4))  u_dut8  (.CLK(CLK), .rst_n(rst_n), .bus(bus8.slave));

  logic [31:0] mem16 [64];
  logic [15:0] mem8  [4];

  always @(posedge CLK) begin
    if (bus16.EN_writeMem) mem16[bus16.writeMem_addr] <= bus16.writeMem_val;
    if (bus16.EN_readMem)  bus16.readMem_val <= mem16[bus16.readMem_addr];
    if (bus8.EN_writeMem)  mem8[bus8.writeMem_addr] <= bus8.writeMem_val;
    if (bus8.EN_readMem)   bus8.readMem_val <= mem8[bus8.readMem_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp16 [$];
  logic [31:0] rdq16 [$];
  logic [31:0] exp8  [$];
  logic [31:0] rdq8  [$];
  int waddr16 = 0, raddr16 = 0, rdcnt16 = 0;
  int waddr8  = 0, raddr8  = 0, rdcnt8  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain integer multiply after sign extension.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input logic s);
    longint pa, pb;
    logic [63:0] p, mask;
    pa = longint'(a);
    pb = longint'(b);
    if (s && a[w-1]) pa = pa - (longint'(1) << w);
    if (s && b[w-1]) pb = pb - (longint'(1) << w);
    p    = 64'(pa * pb);
    mask = (64'd1 << (2 * w)) - 64'd1;
    return 32'(p & mask);
  endfunction

  // Advance one edge, then check every memory write/read against the model.
  task automatic tick();
    @(posedge CLK); #1;
    if (bus16.EN_writeMem === 1'b1) begin
      if (exp16.size() == 0) check("wr16_spurious", bus16.EN_writeMem, 0);
      else begin
        check("wr16_addr", bus16.writeMem_addr, waddr16);
        check("wr16_val", bus16.writeMem_val, exp16.pop_front());
        waddr16++;
      end
    end
    if (bus16.EN_readMem === 1'b1) begin
      check("rd16_addr", bus16.readMem_addr, raddr16);
      raddr16++;
    end
    if (bus16.VALID_memVal === 1'b1) begin
      if (rdq16.size() == 0) check("rd16_spurious", bus16.VALID_memVal, 0);
      else check("rd16_data", bus16.memVal_data, rdq16.pop_front());
      rdcnt16++;
    end
    if (bus8.EN_writeMem === 1'b1) begin
      if (exp8.size() == 0) check("wr8_spurious", bus8.EN_writeMem, 0);
      else begin
        check("wr8_addr", bus8.writeMem_addr, waddr8);
        check("wr8_val", bus8.writeMem_val, exp8.pop_front());
        waddr8++;
      end
    end
    if (bus8.EN_readMem === 1'b1) begin
      check("rd8_addr", bus8.readMem_addr, raddr8);
      raddr8++;
    end
    if (bus8.VALID_memVal === 1'b1) begin
      if (rdq8.size() == 0) check("rd8_spurious", bus8.VALID_memVal, 0);
      else check("rd8_data", bus8.memVal_data, rdq8.pop_front());
      rdcnt8++;
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input logic [31:0] e);
    check("rdy16_before_op", bus16.RDY_mult, 1);
    bus16.EN_mult     = 1'b1;
    bus16.mult_input0 = a;
    bus16.mult_input1 = b;
    bus16.signed_mode = s;
    exp16.push_back(e);
    rdq16.push_back(e);
    tick();
    bus16.EN_mult = 1'b0;
  endtask

  task automatic block_read16(input int n_expected, input int cycles);
    rdcnt16 = 0;
    bus16.EN_blockRead = 1'b1;
    tick();
    bus16.EN_blockRead = 1'b0;
    repeat (cycles) tick();
    check("blk16_read_count", rdcnt16, n_expected);
    check("blk16_rdq_empty", rdq16.size(), 0);
    check("blk16_fill_zero", bus16.fill_count, 0);
    check("blk16_rdy_back", bus16.RDY_mult, 1);
    waddr16 = 0;
    raddr16 = 0;
  endtask

  logic [7:0] ta [4] = '{8'h80, 8'h80, 8'hFF, 8'hFF};
  logic [7:0] tb [4] = '{8'h80, 8'h7F, 8'hFF, 8'hFF};
  logic       ts [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  logic [15:0] te [4] = '{16'h4000, 16'hC080, 16'hFE01, 16'h0001};

  initial begin
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic        s;
    logic [31:0] e;

    bus16.EN_mult = 0; bus16.signed_mode = 0; bus16.mult_input0 = 0;
    bus16.mult_input1 = 0; bus16.EN_blockRead = 0;
    bus8.EN_mult = 0; bus8.signed_mode = 0; bus8.mult_input0 = 0;
    bus8.mult_input1 = 0; bus8.EN_blockRead = 0;

    // Reset state
    repeat (3) tick();
    check("rst_wr_en", bus16.EN_writeMem, 0);
    check("rst_rd_en", bus16.EN_readMem, 0);
    check("rst_fill", bus16.fill_count, 0);
    #3 rst_n = 1'b1;
    tick();
    check("rst_rdy", bus16.RDY_mult, 1);
    check("rst_waddr", bus16.writeMem_addr, 0);
    check("rst_wval", bus16.writeMem_val, 0);
    check("rst_raddr", bus16.readMem_addr, 0);
    check("rst_valid", bus16.VALID_memVal, 0);
    check("rst_rdy8", bus8.RDY_mult, 1);

    // Unsigned 0xFFFF * 0xFFFF and its write latency
    op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
    check("lat_cyc0", bus16.EN_writeMem, 0);
    tick();
    check("lat_cyc1", bus16.EN_writeMem, 0);
    tick();
    check("lat_cyc2_wr", bus16.EN_writeMem, 1);
    check("lat_cyc2_addr", bus16.writeMem_addr, 0);
    check("lat_cyc2_val", bus16.writeMem_val, 32'hFFFE0001);
    tick();
    check("lat_fill1", bus16.fill_count, 1);
    check("lat_wr_done", bus16.EN_writeMem, 0);

    // Signed cases plus the unsigned reading of a negative pattern
    op16(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1);
    op16(16'h8000, 16'h8000, 1'b1, 32'h40000000);
    op16(16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
    op16(16'hFFFD, 16'h0005, 1'b0, 32'h0004FFF1);
    repeat (4) tick();
    check("signed_fill5", bus16.fill_count, 5);
    check("signed_exp_done", exp16.size(), 0);
    block_read16(5, 12);

    // Flush with results still in the pipeline
    for (int i = 0; i < 5; i++) begin
      a16 = 16'h1234 + 16'(i);
      op16(a16, 16'h0100, 1'b0, {8'h00, a16, 8'h00});
    end
    rdcnt16 = 0;
    bus16.EN_blockRead = 1'b1;
    tick();
    bus16.EN_blockRead = 1'b0;
    check("flush_drain_rdy", bus16.RDY_mult, 0);
    bus16.EN_mult = 1'b1;
    bus16.mult_input0 = 16'hFFFF;
    bus16.mult_input1 = 16'hFFFF;
    repeat (2) tick();
    check("flush_ignore_rdy", bus16.RDY_mult, 0);
    bus16.EN_mult = 1'b0;
    repeat (14) tick();
    check("flush_read_count", rdcnt16, 5);
    check("flush_exp_empty", exp16.size(), 0);
    check("flush_rdq_empty", rdq16.size(), 0);
    check("flush_fill0", bus16.fill_count, 0);
    waddr16 = 0;
    raddr16 = 0;
    op16(16'h0003, 16'h0007, 1'b0, 32'h00000015);
    repeat (3) tick();
    check("flush_next_fill1", bus16.fill_count, 1);

    // Reset between edges with two ops in flight
    op16(16'h0101, 16'h0202, 1'b0, 32'h00020402);
    op16(16'h0101, 16'h0202, 1'b0, 32'h00020402);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en", bus16.EN_writeMem, 0);
    check("mid_rst_fill", bus16.fill_count, 0);
    check("mid_rst_waddr", bus16.writeMem_addr, 0);
    check("mid_rst_wval", bus16.writeMem_val, 0);
    exp16.delete();
    rdq16.delete();
    waddr16 = 0;
    raddr16 = 0;
    repeat (2) tick();
    #3 rst_n = 1'b1;
    repeat (5) tick();
    check("mid_rst_rdy", bus16.RDY_mult, 1);
    check("mid_rst_fill_after", bus16.fill_count, 0);

    // Fill: EN_mult held for 70 cycles, exactly 64 accepted
    for (int i = 0; i < 70; i++) begin
      check("fill_rdy", bus16.RDY_mult, (i < 64));
      a16 = 16'(i * 251 + 17);
      b16 = 16'(i * 3 + 5);
      s   = 1'(i % 2);
      bus16.EN_mult = 1'b1;
      bus16.mult_input0 = a16;
      bus16.mult_input1 = b16;
      bus16.signed_mode = s;
      if (i < 64) begin
        e = ref_mul(32'(a16), 32'(b16), 16, s);
        exp16.push_back(e);
        rdq16.push_back(e);
      end
      tick();
    end
    bus16.EN_mult = 1'b0;
    check("full_fill64", bus16.fill_count, 64);
    check("full_exp_empty", exp16.size(), 0);
    check("full_rdy", bus16.RDY_mult, 0);
    repeat (3) tick();
    check("full_wait_rd_en", bus16.EN_readMem, 0);
    block_read16(64, 70);

    // W=8, DEPTH=4: empty-buffer block read is ignored
    bus8.EN_blockRead = 1'b1;
    tick();
    bus8.EN_blockRead = 1'b0;
    check("w8_empty_rdy", bus8.RDY_mult, 1);
    tick();
    check("w8_empty_rd_en", bus8.EN_readMem, 0);
    check("w8_empty_rdy2", bus8.RDY_mult, 1);

    // W=8 blocks: directed corner operands, then random ones
    for (int blk = 0; blk < 3; blk++) begin
      for (int i = 0; i < 6; i++) begin
        check("w8_rdy", bus8.RDY_mult, (i < 4));
        if (blk == 0 && i < 4) begin
          a8 = ta[i]; b8 = tb[i]; s = ts[i]; e = {16'h0, te[i]};
        end else begin
          a8 = 8'($urandom);
          b8 = 8'($urandom);
          s  = 1'($urandom_range(0, 1));
          e  = ref_mul(32'(a8), 32'(b8), 8, s);
        end
        bus8.EN_mult = 1'b1;
        bus8.mult_input0 = a8;
        bus8.mult_input1 = b8;
        bus8.signed_mode = s;
        if (i < 4) begin
          exp8.push_back(e);
          rdq8.push_back(e);
        end
        tick();
      end
      bus8.EN_mult = 1'b0;
      repeat (3) tick();
      check("w8_full_fill4", bus8.fill_count, 4);
      check("w8_full_rdy", bus8.RDY_mult, 0);
      check("w8_exp_empty", exp8.size(), 0);
      rdcnt8 = 0;
      bus8.EN_blockRead = 1'b1;
      tick();
      bus8.EN_blockRead = 1'b0;
      repeat (8) tick();
      check("w8_read_count", rdcnt8, 4);
      check("w8_rdq_empty", rdq8.size(), 0);
      check("w8_fill0", bus8.fill_count, 0);
      waddr8 = 0;
      raddr8 = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_result_buf.md
Name: mult_result_buf

Overview:
- Parametrised successor to the team's 16x16 pipelined multiplier with result buffer.
- Pipelined W x W multiplier supporting unsigned or signed (two's complement) operands, selected per operation.
- Results are written sequentially into an external DEPTH-entry result memory, then drained as a block read.
- Adds back-pressure that loses no results, and a host-requested flush that reads out a partially filled buffer.

Parameters:
- W, 16: operand width; multiple of 4, range 8..32.
- DEPTH, 64: result memory entries; power of 2, range 4..1024.
- AW, $clog2(DEPTH): memory address width (derived).
- N, 2*W: result/memory data width (derived).

Ports:
- CLK  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- EN_mult  in  1  operation request; accepted only when RDY_mult=1.
- signed_mode  in  1  1 = operands are signed; sampled with the operands.
- mult_input0  in  W  operand A.
- mult_input1  in  W  operand B.
- EN_blockRead  in  1  request block read (drain, or flush of a partial buffer).
- readMem_val  in  N  memory read data, valid 1 cycle after EN_readMem.
- RDY_mult  out  1  ready to accept an operation.
- EN_writeMem  out  1  memory write strobe.
- writeMem_addr  out  AW  write address.
- writeMem_val  out  N  product to write.
- EN_readMem  out  1  memory read strobe.
- readMem_addr  out  AW  read address.
- VALID_memVal  out  1  memVal_data is valid this cycle.
- memVal_data  out  N  read data to host; combinational pass-through of readMem_val.
- fill_count  out  AW+1  entries currently written, 0..DEPTH.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE_WRITE; all pipeline valid bits and data registers cleared.
  - Write/read address and fill_count = 0; in-flight count = 0.
  - Outputs: RDY_mult=1 once rst_n is released, all strobes 0, addresses 0, writeMem_val 0.
- Latency and pipeline:
  - An op accepted at edge k produces EN_writeMem=1 with its product in cycle k+3.
  - Stage 0: 4-bit x 4-bit partial products on operand magnitudes; sign_flag = signed_mode & (A[W-1]^B[W-1]).
  - Stage 1: row sums. Stage 2: final sum; two's-complement negation when sign_flag=1.
  - Throughput is one op per cycle; valid and sign_flag travel with the data.
- Signed arithmetic: magnitude of -2^(W-1) is 2^(W-1), held in W bits unsigned. Result is exact in N bits.
- Writes: writeMem_addr = write pointer. The pointer increments after each write; fill_count increments with it.
- Back-pressure: RDY_mult = (state==IDLE_WRITE) && (fill_count + inflight < DEPTH). inflight (0..3) counts accepted ops not yet written. This rule guarantees no result is ever dropped.
- States and transitions:
  - IDLE_WRITE -> FULL when fill_count==DEPTH and inflight==0.
  - IDLE_WRITE -> DRAIN on EN_blockRead when fill_count+inflight>0. EN_blockRead is ignored when the buffer is empty.
  - DRAIN: RDY_mult=0; in-flight results still get written. -> READ when inflight==0.
  - FULL: RDY_mult=0. -> READ on EN_blockRead.
  - READ: EN_readMem=1 every cycle, readMem_addr = 0 .. fill_count-1. After the last address is issued -> IDLE_WRITE, with write pointer, read pointer and fill_count set to 0.
- Read data: VALID_memVal = EN_readMem registered by one cycle. It is therefore high exactly fill_count cycles, including the first cycle back in IDLE_WRITE. New ops may be accepted in that cycle.
- Wrap-around: pointers never wrap inside a block. Writing address DEPTH-1 triggers FULL.
- EN_mult while RDY_mult=0 is ignored; no state change.
- EN_blockRead in DRAIN, READ or FULL-after-transition has no extra effect.
- Reset mid-operation discards in-flight results; no write strobe fires after reset.

Decomposition:
- Package mult_result_buf_pkg holds:
  - state_t enum: IDLE_WRITE, DRAIN, FULL, READ.
  - localparam PIPE_LAT=3.
  - function mag(x, signed) returning the operand magnitude.
- One sub-module, mult_pipe: the W x W 3-stage signed/unsigned multiplier with valid in/out.
- The top level holds the FSM, pointers and counters.

Test Plan:
- Unsigned: A=0xFFFF, B=0xFFFF, signed_mode=0, W=16 -> 3 cycles later EN_writeMem=1, addr 0, val 0xFFFE0001; fill_count=1.
- Signed: A=0xFFFD (-3), B=0x0005 -> 0xFFFFFFF1. A=0x8000, B=0x8000 -> 0x40000000. A=0x8000, B=0x0001 -> 0xFFFF8000.
- Fill: EN_mult held high for 70 cycles -> exactly 64 accepted, RDY_mult low after the 64th. Addresses 0..63 written, then FULL. EN_blockRead -> 64 reads, VALID_memVal high 64 cycles, memory values returned in order.
- Flush: 5 back-to-back ops, EN_blockRead on the cycle after the 5th acceptance -> DRAIN completes all 5 writes, READ addr 0..4, then IDLE_WRITE with fill_count=0. Next op is written to addr 0.
- Reset mid-pipeline: accept 2 ops, drop rst_n asynchronously (between edges) -> outputs clear immediately. No EN_writeMem afterwards; fill_count=0; RDY_mult=1 after release.
- Parameter sweep: W=8, DEPTH=4, random signed and unsigned ops checked against a reference model. FULL after 4 writes; the empty-buffer EN_blockRead is ignored.
